id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have: clk_i  in  1  pipeline clock, all state rises on posedge.
REQ-002 SHALL have: rst_i  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: mem_stall_i  in  1  memory/cache stall; freezes the register.
REQ-004 SHALL have: flush_i  in  1  branch-taken squash of the ID-stage instruction.
REQ-005 SHALL have: stall_i  in  1  load-use hazard flag (same signal driving the control-zeroing mux); marks the incoming entry a bubble.
REQ-006 SHALL have: valid_i  in  1  ID stage holds a real instruction.
REQ-007 SHALL have: ALUSrc_i, MemToReg_i, RegWrite_i, MemWrite_i, MemRead_i, Branch_i  in  1 each  control bits after stall zeroing.
REQ-008 SHALL have: ALUOp_i  in  2  ALU operation class.
REQ-009 SHALL have: pc_i, rs1_data_i, rs2_data_i, imm_i  in  32 each  ID-stage datapath values.
REQ-010 SHALL have: funct_i  in  10  {funct7, funct3}; rs1_addr_i, rs2_addr_i, rd_addr_i  in  5 each.
REQ-011 SHALL have one registered output per data/control input, same name with _o suffix, same width.
REQ-012 SHALL have: valid_o  out  1  EX entry is a real instruction.
REQ-013 SHALL have: bubble_cnt_o  out  16  saturating count of bubbles inserted.

Function
REQ-014 Priority per posedge SHALL be: reset > mem_stall_i > flush_i > stall_i > normal load.
REQ-015 mem_stall_i=1 SHALL hold every output, valid_o and bubble_cnt_o unchanged, regardless of flush_i/stall_i.
REQ-016 flush_i=1 (mem_stall_i=0) SHALL load a bubble: all seven control outputs 0, ALUOp_o=2'b00, valid_o=0; datapath outputs are loaded from inputs (don't-care).
REQ-017 stall_i=1 (mem_stall_i=0, flush_i=0) SHALL load a bubble identically to REQ-016, independent of incoming control values.
REQ-018 Normal load SHALL capture all inputs; valid_o <= valid_i; latency exactly 1 cycle.
REQ-019 valid_i=0 with no flush/stall SHALL load control bits as given but force RegWrite_o=MemWrite_o=MemRead_o=Branch_o=0.
REQ-020 bubble_cnt_o SHALL increment by 1 on each non-held cycle where flush_i or stall_i loads a bubble; flush and stall together count once.
REQ-021 bubble_cnt_o SHALL saturate at 16'hFFFF, never wrap.
REQ-022 No combinational path from any input to any output.

Reset
REQ-023 rst_i=0 SHALL immediately (asynchronously) clear every output, valid_o and bubble_cnt_o to 0.
REQ-024 Reset deassertion SHALL take effect at the next posedge; first post-reset edge performs a normal load.
REQ-025 Reset mid-stall SHALL discard held contents; mem_stall_i after reset holds zeros.

Structure
REQ-026 Shared package cpu_pkg SHALL hold XLEN=32, REG_ADDR_W=5, FUNCT_W=10, CNT_W=16 and ALUOp encodings (ALUOP_ADD_LS=2'b00, ALUOP_BRANCH=2'b01, ALUOP_RTYPE=2'b10, ALUOP_ITYPE=2'b11).
REQ-027 The saturating counter SHALL be a sub-module sat_counter (parameter width; inputs clk_i, rst_i, en_i; output count_o).
REQ-028 Remaining logic SHALL be a single flat register stage with one next-state selection per REQ-014.

Verification
REQ-029 Normal: valid_i=1, RegWrite_i=1, ALUOp_i=2'b10, rs1_data_i=32'h0000_0005, rd_addr_i=5'd7 -> next edge RegWrite_o=1, ALUOp_o=2'b10, rs1_data_o=5, rd_addr_o=7, valid_o=1.
REQ-030 Hold: load pc_i=32'h100, then mem_stall_i=1 for 3 cycles with pc_i=32'h104, flush_i=1 -> pc_o stays 32'h100, valid_o=1, bubble_cnt_o unchanged; release -> flush bubble loaded, count +1.
REQ-031 Flush+stall same edge with MemRead_i=1 -> all controls 0, valid_o=0, bubble_cnt_o increments by exactly 1.
REQ-032 Saturation: preload counter to 16'hFFFE, two stall bubbles -> 16'hFFFF, then stays 16'hFFFF.
REQ-033 Async reset: assert rst_i=0 mid-cycle during mem_stall_i=1 with RegWrite_o=1 -> outputs 0 before next edge; after release with mem_stall_i=1 outputs remain 0.
REQ-034 Invalid entry: valid_i=0, MemWrite_i=1, ALUSrc_i=1 -> MemWrite_o=0, ALUSrc_o=1, valid_o=0, counter unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, ALUOp encodings and the ID/EX entry layout.
package cpu_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam int FUNCT_W = 10;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {
    ALUOP_ADD_LS = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } aluOp_e;
  typedef struct packed {
    logic aluSrc;
    logic memToReg;
    logic regWrite;
    logic memWrite;
    logic memRead;
    logic branch;
    logic [1:0] aluOp;
  } ctrl_t;
  typedef struct packed {
    logic valid;
    ctrl_t ctrl;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1Data;
    logic [XLEN-1:0] rs2Data;
    logic [XLEN-1:0] imm;
    logic [FUNCT_W-1:0] funct;
    logic [REG_ADDR_W-1:0] rs1Addr;
    logic [REG_ADDR_W-1:0] rs2Addr;
    logic [REG_ADDR_W-1:0] rdAddr;
  } entry_t;
  // An invalid entry may carry decode bits, but must never change architectural state.
  function automatic ctrl_t killSideEffects(ctrl_t c);
    ctrl_t r = c;
    r.regWrite = 1'b0;
    r.memWrite = 1'b0;
    r.memRead = 1'b0;
    r.branch = 1'b0;
    return r;
  endfunction
endpackage

// File: rtl/id_ex_reg_if.sv
// id_ex_reg_if: ID-stage inputs and EX-stage outputs of the ID/EX pipeline register.
interface id_ex_reg_if;
  import cpu_pkg::*;
  logic mem_stall_i, flush_i, stall_i, valid_i;
  logic ALUSrc_i, MemToReg_i, RegWrite_i, MemWrite_i, MemRead_i, Branch_i;
  logic [1:0] ALUOp_i;
  logic [XLEN-1:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
  logic [FUNCT_W-1:0] funct_i;
  logic [REG_ADDR_W-1:0] rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic valid_o;
  logic ALUSrc_o, MemToReg_o, RegWrite_o, MemWrite_o, MemRead_o, Branch_o;
  logic [1:0] ALUOp_o;
  logic [XLEN-1:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
  logic [FUNCT_W-1:0] funct_o;
  logic [REG_ADDR_W-1:0] rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [CNT_W-1:0] bubble_cnt_o;
  modport master (
    output mem_stall_i, flush_i, stall_i, valid_i,
    output ALUSrc_i, MemToReg_i, RegWrite_i, MemWrite_i, MemRead_i, Branch_i, ALUOp_i,
    output pc_i, rs1_data_i, rs2_data_i, imm_i, funct_i, rs1_addr_i, rs2_addr_i, rd_addr_i,
    input valid_o, ALUSrc_o, MemToReg_o, RegWrite_o, MemWrite_o, MemRead_o, Branch_o, ALUOp_o,
    input pc_o, rs1_data_o, rs2_data_o, imm_o, funct_o, rs1_addr_o, rs2_addr_o, rd_addr_o,
    input bubble_cnt_o
  );
  modport slave (
    input mem_stall_i, flush_i, stall_i, valid_i,
    input ALUSrc_i, MemToReg_i, RegWrite_i, MemWrite_i, MemRead_i, Branch_i, ALUOp_i,
    input pc_i, rs1_data_i, rs2_data_i, imm_i, funct_i, rs1_addr_i, rs2_addr_i, rd_addr_i,
    output valid_o, ALUSrc_o, MemToReg_o, RegWrite_o, MemWrite_o, MemRead_o, Branch_o, ALUOp_o,
    output pc_o, rs1_data_o, rs2_data_o, imm_o, funct_o, rs1_addr_o, rs2_addr_o, rd_addr_o,
    output bubble_cnt_o
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [width-1:0] count_o
);
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) count_o <= '0;
    else if (en_i && count_o != '1) count_o <= count_o + width'(1);
endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with hold, bubble insertion and a bubble counter.
module id_ex_reg
  import cpu_pkg::*;
(
  input logic clk_i,
  input logic rst_i,
  id_ex_reg_if.slave bus
);
  entry_t inEntry, nextEntry, curEntry;
  logic bubble;
  assign bubble = bus.flush_i | bus.stall_i;
  assign inEntry = '{
    valid: bus.valid_i,
    ctrl: '{aluSrc: bus.ALUSrc_i, memToReg: bus.MemToReg_i, regWrite: bus.RegWrite_i,
            memWrite: bus.MemWrite_i, memRead: bus.MemRead_i, branch: bus.Branch_i,
            aluOp: bus.ALUOp_i},
    pc: bus.pc_i, rs1Data: bus.rs1_data_i, rs2Data: bus.rs2_data_i, imm: bus.imm_i,
    funct: bus.funct_i, rs1Addr: bus.rs1_addr_i, rs2Addr: bus.rs2_addr_i, rdAddr: bus.rd_addr_i
  };
  // Datapath fields always follow the inputs; only control and valid are squashed.
  always_comb begin
    nextEntry = inEntry;
    nextEntry.valid = bus.valid_i & ~bubble;
    nextEntry.ctrl = bubble ? ctrl_t'(0) : bus.valid_i ? inEntry.ctrl : killSideEffects(inEntry.ctrl);
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) curEntry <= '0;
    else if (!bus.mem_stall_i) curEntry <= nextEntry;
  sat_counter #(.width(CNT_W)) uBubbleCnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en_i(~bus.mem_stall_i & bubble),
    .count_o(bus.bubble_cnt_o)
  );
  assign bus.valid_o = curEntry.valid;
  assign bus.ALUSrc_o = curEntry.ctrl.aluSrc;
  assign bus.MemToReg_o = curEntry.ctrl.memToReg;
  assign bus.RegWrite_o = curEntry.ctrl.regWrite;
  assign bus.MemWrite_o = curEntry.ctrl.memWrite;
  assign bus.MemRead_o = curEntry.ctrl.memRead;
  assign bus.Branch_o = curEntry.ctrl.branch;
  assign bus.ALUOp_o = curEntry.ctrl.aluOp;
  assign bus.pc_o = curEntry.pc;
  assign bus.rs1_data_o = curEntry.rs1Data;
  assign bus.rs2_data_o = curEntry.rs2Data;
  assign bus.imm_o = curEntry.imm;
  assign bus.funct_o = curEntry.funct;
  assign bus.rs1_addr_o = curEntry.rs1Addr;
  assign bus.rs2_addr_o = curEntry.rs2Addr;
  assign bus.rd_addr_o = curEntry.rdAddr;
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: randomized and directed checks of id_ex_reg against a rule-level reference model.
module tb_id_ex_reg;
  import cpu_pkg::*;
  localparam int DW = 4*XLEN + FUNCT_W + 3*REG_ADDR_W;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  id_ex_reg_if bus();
  id_ex_reg dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
  always #5 clk_i = ~clk_i;
  int checks = 0, failures = 0;
  ctrl_t mCtrl;
  logic mValid;
  logic [DW-1:0] mData;
  int mCnt;
  bit mDataKnown;
  function automatic ctrl_t inCtrl();
    return '{bus.ALUSrc_i, bus.MemToReg_i, bus.RegWrite_i, bus.MemWrite_i, bus.MemRead_i, bus.Branch_i, bus.ALUOp_i};
  endfunction
  function automatic ctrl_t outCtrl();
    return '{bus.ALUSrc_o, bus.MemToReg_o, bus.RegWrite_o, bus.MemWrite_o, bus.MemRead_o, bus.Branch_o, bus.ALUOp_o};
  endfunction
  function automatic logic [DW-1:0] inData();
    return {bus.pc_i, bus.rs1_data_i, bus.rs2_data_i, bus.imm_i, bus.funct_i, bus.rs1_addr_i, bus.rs2_addr_i, bus.rd_addr_i};
  endfunction
  function automatic logic [DW-1:0] outData();
    return {bus.pc_o, bus.rs1_data_o, bus.rs2_data_o, bus.imm_o, bus.funct_o, bus.rs1_addr_o, bus.rs2_addr_o, bus.rd_addr_o};
  endfunction
  task automatic modelReset();
    mCtrl = '0; mValid = 1'b0; mData = '0; mCnt = 0; mDataKnown = 1'b1;
  endtask
  // Reference behaviour for one rising edge, evaluated on the inputs present at that edge.
  task automatic modelEdge();
    if (rst_i && !bus.mem_stall_i) begin
      mData = inData();
      mDataKnown = 1'b1;
      if (bus.flush_i || bus.stall_i) begin
        mCtrl = '0; mValid = 1'b0; mDataKnown = 1'b0;
        if (mCnt < 65535) mCnt++;
      end else begin
        mCtrl = inCtrl();
        mValid = bus.valid_i;
        if (!bus.valid_i) begin
          mCtrl.regWrite = 1'b0; mCtrl.memWrite = 1'b0; mCtrl.memRead = 1'b0; mCtrl.branch = 1'b0;
        end
      end
    end
  endtask
  task automatic step();
    @(posedge clk_i);
    modelEdge();
    #1;
  endtask
  task automatic clearIn();
    bus.mem_stall_i = 0; bus.flush_i = 0; bus.stall_i = 0; bus.valid_i = 0;
    bus.ALUSrc_i = 0; bus.MemToReg_i = 0; bus.RegWrite_i = 0; bus.MemWrite_i = 0;
    bus.MemRead_i = 0; bus.Branch_i = 0; bus.ALUOp_i = 0;
    bus.pc_i = 0; bus.rs1_data_i = 0; bus.rs2_data_i = 0; bus.imm_i = 0;
    bus.funct_i = 0; bus.rs1_addr_i = 0; bus.rs2_addr_i = 0; bus.rd_addr_i = 0;
  endtask
  task automatic randIn(int pBubble, int pMem);
    logic [31:0] r, s;
    r = $urandom; s = $urandom;
    bus.ALUSrc_i = r[0]; bus.MemToReg_i = r[1]; bus.RegWrite_i = r[2]; bus.MemWrite_i = r[3];
    bus.MemRead_i = r[4]; bus.Branch_i = r[5]; bus.ALUOp_i = r[7:6]; bus.valid_i = r[8];
    bus.funct_i = r[18:9]; bus.rs1_addr_i = r[23:19]; bus.rs2_addr_i = r[28:24]; bus.rd_addr_i = s[4:0];
    bus.pc_i = $urandom; bus.rs1_data_i = $urandom; bus.rs2_data_i = $urandom; bus.imm_i = $urandom;
    bus.flush_i = $urandom_range(99) < pBubble;
    bus.stall_i = $urandom_range(99) < pBubble;
    bus.mem_stall_i = $urandom_range(99) < pMem;
  endtask
  task automatic test_reset();
    clearIn();
    modelReset();
    #2;
    checks++; if (outCtrl() !== ctrl_t'(0)) begin failures++; $display("FAIL reset_ctrl got %h exp 0", outCtrl()); end
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", bus.valid_o); end
    checks++; if (outData() !== '0) begin failures++; $display("FAIL reset_data got %h exp 0", outData()); end
    checks++; if (bus.bubble_cnt_o !== 16'h0) begin failures++; $display("FAIL reset_cnt got %h exp 0", bus.bubble_cnt_o); end
    #4 rst_i = 1'b1;
  endtask
  task automatic test_normal();
    clearIn();
    bus.valid_i = 1; bus.RegWrite_i = 1; bus.ALUOp_i = 2'b10; bus.rs1_data_i = 32'h5; bus.rd_addr_i = 5'd7;
    step();
    checks++; if (bus.RegWrite_o !== 1'b1) begin failures++; $display("FAIL normal_regwrite got %b exp 1", bus.RegWrite_o); end
    checks++; if (bus.ALUOp_o !== 2'b10) begin failures++; $display("FAIL normal_aluop got %b exp 10", bus.ALUOp_o); end
    checks++; if (bus.rs1_data_o !== 32'h5) begin failures++; $display("FAIL normal_rs1 got %h exp 5", bus.rs1_data_o); end
    checks++; if (bus.rd_addr_o !== 5'd7) begin failures++; $display("FAIL normal_rd got %0d exp 7", bus.rd_addr_o); end
    checks++; if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL normal_valid got %b exp 1", bus.valid_o); end
  endtask
  task automatic test_hold();
    int held;
    clearIn();
    bus.valid_i = 1; bus.pc_i = 32'h100;
    step();
    held = mCnt;
    bus.mem_stall_i = 1; bus.flush_i = 1; bus.pc_i = 32'h104;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.pc_o !== 32'h100) begin failures++; $display("FAIL hold_pc cyc %0d got %h exp 100", i, bus.pc_o); end
      checks++; if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL hold_valid cyc %0d got %b exp 1", i, bus.valid_o); end
      checks++; if (bus.bubble_cnt_o !== 16'(held)) begin failures++; $display("FAIL hold_cnt cyc %0d got %h exp %h", i, bus.bubble_cnt_o, 16'(held)); end
    end
    bus.mem_stall_i = 0;
    step();
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL hold_release_valid got %b exp 0", bus.valid_o); end
    checks++; if (bus.bubble_cnt_o !== 16'(held + 1)) begin failures++; $display("FAIL hold_release_cnt got %h exp %h", bus.bubble_cnt_o, 16'(held + 1)); end
  endtask
  task automatic test_flush_stall();
    int c0;
    randIn(0, 0);
    bus.flush_i = 1; bus.stall_i = 1; bus.valid_i = 1; bus.MemRead_i = 1; bus.RegWrite_i = 1; bus.ALUOp_i = 2'b11;
    c0 = mCnt;
    step();
    checks++; if (outCtrl() !== ctrl_t'(0)) begin failures++; $display("FAIL fs_ctrl got %h exp 0", outCtrl()); end
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL fs_valid got %b exp 0", bus.valid_o); end
    checks++; if (bus.bubble_cnt_o !== 16'(c0 + 1)) begin failures++; $display("FAIL fs_cnt got %h exp %h", bus.bubble_cnt_o, 16'(c0 + 1)); end
  endtask
  task automatic test_invalid();
    int c0;
    randIn(0, 0);
    bus.valid_i = 0; bus.MemWrite_i = 1; bus.ALUSrc_i = 1; bus.RegWrite_i = 1; bus.MemRead_i = 1; bus.Branch_i = 1;
    c0 = mCnt;
    step();
    checks++; if (bus.MemWrite_o !== 1'b0) begin failures++; $display("FAIL inv_memwrite got %b exp 0", bus.MemWrite_o); end
    checks++; if (bus.ALUSrc_o !== 1'b1) begin failures++; $display("FAIL inv_alusrc got %b exp 1", bus.ALUSrc_o); end
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL inv_valid got %b exp 0", bus.valid_o); end
    checks++; if (bus.bubble_cnt_o !== 16'(c0)) begin failures++; $display("FAIL inv_cnt got %h exp %h", bus.bubble_cnt_o, 16'(c0)); end
    checks++; if (outCtrl() !== mCtrl) begin failures++; $display("FAIL inv_ctrl got %h exp %h", outCtrl(), mCtrl); end
    checks++; if (outData() !== mData) begin failures++; $display("FAIL inv_data got %h exp %h", outData(), mData); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      randIn(20, 20);
      step();
      checks++; if (outCtrl() !== mCtrl) begin failures++; $display("FAIL rand_ctrl cyc %0d got %h exp %h", i, outCtrl(), mCtrl); end
      checks++; if (bus.valid_o !== mValid) begin failures++; $display("FAIL rand_valid cyc %0d got %b exp %b", i, bus.valid_o, mValid); end
      checks++; if (bus.bubble_cnt_o !== 16'(mCnt)) begin failures++; $display("FAIL rand_cnt cyc %0d got %h exp %h", i, bus.bubble_cnt_o, 16'(mCnt)); end
      if (mDataKnown) begin
        checks++; if (outData() !== mData) begin failures++; $display("FAIL rand_data cyc %0d got %h exp %h", i, outData(), mData); end
      end
    end
  endtask
  task automatic test_async_reset();
    clearIn();
    bus.valid_i = 1; bus.RegWrite_i = 1; bus.pc_i = 32'hABC;
    step();
    checks++; if (bus.RegWrite_o !== 1'b1) begin failures++; $display("FAIL ar_preload got %b exp 1", bus.RegWrite_o); end
    bus.mem_stall_i = 1;
    step();
    #3 rst_i = 1'b0;
    modelReset();
    #1;
    checks++; if (outCtrl() !== ctrl_t'(0)) begin failures++; $display("FAIL ar_ctrl got %h exp 0", outCtrl()); end
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL ar_valid got %b exp 0", bus.valid_o); end
    checks++; if (outData() !== '0) begin failures++; $display("FAIL ar_data got %h exp 0", outData()); end
    checks++; if (bus.bubble_cnt_o !== 16'h0) begin failures++; $display("FAIL ar_cnt got %h exp 0", bus.bubble_cnt_o); end
    #2 rst_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      randIn(50, 0);
      bus.mem_stall_i = 1;
      step();
      checks++; if (outCtrl() !== ctrl_t'(0) || bus.valid_o !== 1'b0) begin failures++; $display("FAIL ar_hold_ctrl cyc %0d got %h/%b exp 0/0", i, outCtrl(), bus.valid_o); end
      checks++; if (outData() !== '0 || bus.bubble_cnt_o !== 16'h0) begin failures++; $display("FAIL ar_hold_data cyc %0d got %h/%h exp 0/0", i, outData(), bus.bubble_cnt_o); end
    end
  endtask
  task automatic test_saturation();
    clearIn();
    rst_i = 1'b0;
    #1;
    modelReset();
    checks++; if (bus.bubble_cnt_o !== 16'h0) begin failures++; $display("FAIL sat_start got %h exp 0", bus.bubble_cnt_o); end
    rst_i = 1'b1;
    bus.stall_i = 1;
    repeat (65534) step();
    checks++; if (bus.bubble_cnt_o !== 16'hFFFE) begin failures++; $display("FAIL sat_preload got %h exp fffe", bus.bubble_cnt_o); end
    step();
    checks++; if (bus.bubble_cnt_o !== 16'hFFFF) begin failures++; $display("FAIL sat_first got %h exp ffff", bus.bubble_cnt_o); end
    step();
    checks++; if (bus.bubble_cnt_o !== 16'hFFFF) begin failures++; $display("FAIL sat_second got %h exp ffff", bus.bubble_cnt_o); end
    bus.flush_i = 1;
    step();
    checks++; if (bus.bubble_cnt_o !== 16'(mCnt)) begin failures++; $display("FAIL sat_stay got %h exp %h", bus.bubble_cnt_o, 16'(mCnt)); end
  endtask
  initial begin
    test_reset();
    test_normal();
    test_hold();
    test_flush_stall();
    test_invalid();
    test_random();
    test_async_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
